pool_engine: RTL and testbench
==============================

Name: pool_engine

Overview:
- Parametrised successor to the CNN pooling unit.
- Reads a signed M×N activation matrix from memory and computes non-overlapping Pm×Pn window pooling (stride = window size). Writes the pooled ⌊M/Pm⌋×⌊N/Pn⌋ matrix back to memory, row-major.
- Window size, matrix size and addresses are runtime software configuration. Sits between the SW register block and the memory arbiter, alongside the CNN/FC engines.

Parameters:
ADDR_WIDTH, 12, memory element address width
DATA_W, 8, signed element width
DIM_W, 8, width of matrix row/column counts
MAX_WIN, 4, largest supported window edge
WIN_W, $clog2(MAX_WIN+1), window-size field width
ACC_W, DATA_W+2*$clog2(MAX_WIN), accumulator width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
sw_start  in  1  one-cycle start pulse
sw_rd_addr  in  ADDR_WIDTH  source matrix base address
sw_wr_addr  in  ADDR_WIDTH  result base address
sw_m  in  DIM_W  source rows
sw_n  in  DIM_W  source columns
sw_pm  in  WIN_W  window rows
sw_pn  in  WIN_W  window columns
sw_mode  in  1  0=max, 1=average (AVG_POOL_EN only)
busy  out  1  engine active
done  out  1  one-cycle completion pulse
err  out  1  config error, held until next start
rd_req  out  1  read request
rd_addr  out  ADDR_WIDTH  read address
rd_gnt  in  1  read accepted
rd_rvalid  in  1  read data valid
rd_rdata  in  DATA_W  read data
wr_req  out  1  write request
wr_addr  out  ADDR_WIDTH  write address
wr_data  out  DATA_W  write data
wr_gnt  in  1  write accepted

Behaviour:
- Clock and reset: single clock clk; rst_n synchronous active-low. Reset values: all outputs 0, FSM in IDLE, counters 0.
- Reset mid-operation: aborts immediately; requests drop the next edge; no done pulse.
- Config latch: on sw_start in IDLE, all sw_* inputs are latched. sw_start while busy is ignored.
- Config check (CHECK, 1 cycle): error if pm=0, pn=0, pm>MAX_WIN, pn>MAX_WIN, m<pm or n<pn. On error: err=1, done pulse, no memory access, back to IDLE.
- FSM: IDLE -> CHECK -> RD_REQ -> RD_WAIT -> (RD_REQ | WR_REQ) -> (RD_REQ | DONE) -> IDLE.
- Counters: orow, ocol (output position); wr_i, wc_i (window position).
- Read address: rd_addr = rd_base + (orow*pm + wr_i)*n + ocol*pn + wc_i, truncated to ADDR_WIDTH (wrap-around allowed, no error).
- Read handshake:
  - rd_req and rd_addr are held stable until the cycle rd_gnt=1.
  - Exactly one read outstanding.
  - rd_rvalid arrives ≥1 cycle after the grant, with arbitrary latency.
  - rd_rvalid outside RD_WAIT is ignored.
- Accumulate:
  - First element of a window initialises the accumulator.
  - Max mode: signed compare; ties keep the held value.
  - Sum uses ACC_W signed, with no overflow possible.
- Window iteration: wc_i increments first, then wr_i. After the last element, go to WR_REQ.
- Write handshake:
  - wr_addr = wr_base + orow*(m/pn_out) … defined as wr_base + orow*OC + ocol, with OC=⌊n/pn⌋ and OR=⌊m/pm⌋.
  - wr_req, wr_addr and wr_data are held until wr_gnt.
  - After the grant, ocol advances, then orow. After the last output, go to DONE.
- Leftovers: rows/columns beyond OR*pm and OC*pn are never read.
- DONE: done=1 for one cycle, busy=0 the same cycle. busy=1 from the cycle after sw_start through the last write grant.
- Write-back of the result is in order; single element per transaction.
- Minimum latency per output: pm*pn*(2 cycles) + 1 write cycle, with zero-wait grants and 1-cycle rdata.

Optional Feature:
- Macro: AVG_POOL_EN.
- Defined: sw_mode=1 selects average mode. The sum is arithmetic-shifted right by log2(pm*pn), rounding toward −inf, and the low DATA_W bits are written. pm and pn must each be powers of two (1, 2 or 4); otherwise CHECK flags err.
- Undefined: sw_mode is ignored, only max mode exists, and the sum and shift logic is not instantiated.

Decomposition:
- Package pool_pkg:
  - FSM state enum (IDLE, CHECK, RD_REQ, RD_WAIT, WR_REQ, DONE).
  - Mode enum (POOL_MAX, POOL_AVG).
  - Default DATA_W/ADDR_WIDTH constants.
- Sub-module pool_addr_gen: counters and address arithmetic, with step/last outputs.
- pool_engine keeps the FSM, accumulator and handshakes.

Test Plan:
- 4×4 matrix 0..15 at rd 0x100, pm=pn=2, max, zero-wait memory -> 4 writes at 0x200..0x203 = 5, 7, 13, 15; done once; busy low after.
- 5×7 signed matrix, pm=2, pn=3, values all −128 except one 127 per window -> 2×2 outputs = 127. Row 4 and column 6 are never read (address monitor).
- Random rd_gnt/wr_gnt stalls (0–5 cycles) and rdata latency 1–8 on the 4×4 case -> identical results. Request signals stable while ungranted; never 2 reads outstanding.
- Config pm=0, then m=3 with pm=4, then pn=5 -> err=1 and done pulse each time, zero rd_req; err clears on the next valid start.
- AVG_POOL_EN: 2×2 window {−1,−2,−3,−4} -> −3 (−10>>2). {1,1,1,2} -> 1. pm=3 in avg mode -> err.
- rst_n low mid-read with request pending -> rd_req=0 next cycle, busy=0, no done. A subsequent start runs cleanly.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling engine.
package pool_pkg;

  localparam int unsigned PoolDataW     = 8;
  localparam int unsigned PoolAddrWidth = 12;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StRdReq,
    StRdWait,
    StWrReq,
    StDone
  } pool_state_e;

  typedef enum logic {
    PoolMax = 1'b0,
    PoolAvg = 1'b1
  } pool_mode_e;

  // Log2 of a window edge already known to be a power of two.
  function automatic logic [3:0] pow2_log2(input logic [7:0] val);
    logic [3:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      if (val[i]) res = 4'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/output position counters plus source and result address generation.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = PoolAddrWidth,
  parameter int unsigned DIM_W      = 8,
  parameter int unsigned WIN_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  step_rd,
  input  logic                  step_wr,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  input  logic [DIM_W-1:0]      m,
  input  logic [DIM_W-1:0]      n,
  input  logic [WIN_W-1:0]      pm,
  input  logic [WIN_W-1:0]      pn,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  win_first,
  output logic                  win_last,
  output logic                  out_last
);

  localparam int unsigned SpanW = DIM_W + WIN_W + 1;

  logic [DIM_W-1:0]      orow_q, orow_d, ocol_q, ocol_d;
  logic [WIN_W-1:0]      wr_i_q, wr_i_d, wc_i_q, wc_i_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] src_row, src_col;
  logic [SpanW-1:0]      col_next_end, row_next_end;
  logic                  wc_last, wr_last, col_last, row_last;

  assign wc_last   = wc_i_q == pn - WIN_W'(1);
  assign wr_last   = wr_i_q == pm - WIN_W'(1);
  assign win_first = (wc_i_q == '0) && (wr_i_q == '0);
  assign win_last  = wc_last && wr_last;

  // Last output column/row when the following window would not fit entirely.
  assign col_next_end = (SpanW'(ocol_q) + SpanW'(2)) * SpanW'(pn);
  assign row_next_end = (SpanW'(orow_q) + SpanW'(2)) * SpanW'(pm);
  assign col_last     = col_next_end > SpanW'(n);
  assign row_last     = row_next_end > SpanW'(m);
  assign out_last     = col_last && row_last;

  // Modular arithmetic, so truncating each term early gives the same wrapped address.
  assign src_row = ADDR_WIDTH'(orow_q) * ADDR_WIDTH'(pm) + ADDR_WIDTH'(wr_i_q);
  assign src_col = ADDR_WIDTH'(ocol_q) * ADDR_WIDTH'(pn) + ADDR_WIDTH'(wc_i_q);
  assign rd_addr = rd_base + src_row * ADDR_WIDTH'(n) + src_col;

  // Outputs are produced in row-major order, so a running pointer equals wr_base + orow*OC + ocol.
  assign wr_addr = wr_ptr_q;

  always_comb begin
    orow_d   = orow_q;
    ocol_d   = ocol_q;
    wr_i_d   = wr_i_q;
    wc_i_d   = wc_i_q;
    wr_ptr_d = wr_ptr_q;
    if (clear) begin
      orow_d   = '0;
      ocol_d   = '0;
      wr_i_d   = '0;
      wc_i_d   = '0;
      wr_ptr_d = wr_base;
    end else begin
      if (step_rd) begin
        if (wc_last) begin
          wc_i_d = '0;
          wr_i_d = wr_last ? '0 : wr_i_q + WIN_W'(1);
        end else begin
          wc_i_d = wc_i_q + WIN_W'(1);
        end
      end
      if (step_wr) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (col_last) begin
          ocol_d = '0;
          orow_d = orow_q + DIM_W'(1);
        end else begin
          ocol_d = ocol_q + DIM_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      orow_q   <= '0;
      ocol_q   <= '0;
      wr_i_q   <= '0;
      wc_i_q   <= '0;
      wr_ptr_q <= '0;
    end else begin
      orow_q   <= orow_d;
      ocol_q   <= ocol_d;
      wr_i_q   <= wr_i_d;
      wc_i_q   <= wc_i_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/pool_engine.sv
// Non-overlapping window pooling engine: reads a signed matrix, writes the pooled result.
// Average pooling is built only when AVG_POOL_EN is defined; otherwise max pooling only.
module pool_engine
  import pool_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = PoolAddrWidth,
  parameter int unsigned DATA_W     = PoolDataW,
  parameter int unsigned DIM_W      = 8,
  parameter int unsigned MAX_WIN    = 4,
  parameter int unsigned WIN_W      = $clog2(MAX_WIN + 1),
  parameter int unsigned ACC_W      = DATA_W + 2 * $clog2(MAX_WIN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_start,
  input  logic [ADDR_WIDTH-1:0] sw_rd_addr,
  input  logic [ADDR_WIDTH-1:0] sw_wr_addr,
  input  logic [DIM_W-1:0]      sw_m,
  input  logic [DIM_W-1:0]      sw_n,
  input  logic [WIN_W-1:0]      sw_pm,
  input  logic [WIN_W-1:0]      sw_pn,
  input  logic                  sw_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_gnt,
  input  logic                  rd_rvalid,
  input  logic [DATA_W-1:0]     rd_rdata,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_gnt
);

  pool_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]    rd_base_q, wr_base_q;
  logic [DIM_W-1:0]         m_q, n_q;
  logic [WIN_W-1:0]         pm_q, pn_q;
  logic                     err_q, err_d;
  logic signed [DATA_W-1:0] max_q, max_d, rdata_s;
  logic                     cfg_load, cfg_bad, take_data, step_wr;
  logic [ADDR_WIDTH-1:0]    gen_rd_addr, gen_wr_addr;
  logic                     win_first, win_last, out_last;
  logic [DATA_W-1:0]        result;

  assign cfg_load  = (state_q == StIdle) && sw_start;
  assign take_data = (state_q == StRdWait) && rd_rvalid;
  assign rdata_s   = $signed(rd_rdata);

  pool_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DIM_W     (DIM_W),
    .WIN_W     (WIN_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q == StCheck),
    .step_rd  (take_data),
    .step_wr  (step_wr),
    .rd_base  (rd_base_q),
    .wr_base  (wr_base_q),
    .m        (m_q),
    .n        (n_q),
    .pm       (pm_q),
    .pn       (pn_q),
    .rd_addr  (gen_rd_addr),
    .wr_addr  (gen_wr_addr),
    .win_first(win_first),
    .win_last (win_last),
    .out_last (out_last)
  );

`ifdef AVG_POOL_EN
  pool_mode_e               mode_q;
  logic signed [ACC_W-1:0]  sum_q, sum_d, sum_shr, rdata_ext;
  logic [3:0]               shamt;

  assign rdata_ext = {{(ACC_W - DATA_W){rd_rdata[DATA_W-1]}}, rd_rdata};
  assign shamt     = pow2_log2(8'(pm_q)) + pow2_log2(8'(pn_q));
  assign sum_shr   = sum_q >>> shamt;
  assign result    = (mode_q == PoolAvg) ? sum_shr[DATA_W-1:0] : max_q;

  always_comb begin
    sum_d = sum_q;
    if (take_data) sum_d = (win_first ? '0 : sum_q) + rdata_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= PoolMax;
      sum_q  <= '0;
    end else begin
      if (cfg_load) mode_q <= pool_mode_e'(sw_mode);
      sum_q <= sum_d;
    end
  end
`else
  logic       unused_mode;
  logic [7:0] unused_acc_w;
  assign unused_mode  = sw_mode;
  assign unused_acc_w = 8'(ACC_W);
  assign result       = max_q;
`endif

  always_comb begin
    cfg_bad = (pm_q == '0) || (pn_q == '0) ||
              (pm_q > WIN_W'(MAX_WIN)) || (pn_q > WIN_W'(MAX_WIN)) ||
              (m_q < DIM_W'(pm_q)) || (n_q < DIM_W'(pn_q));
`ifdef AVG_POOL_EN
    // Averaging is a pure shift, so both window edges must be powers of two.
    if (mode_q == PoolAvg) begin
      cfg_bad = cfg_bad || ((pm_q & (pm_q - WIN_W'(1))) != '0) ||
                ((pn_q & (pn_q - WIN_W'(1))) != '0);
    end
`endif
  end

  // Strict compare: ties keep the held value.
  always_comb begin
    max_d = max_q;
    if (take_data && (win_first || (rdata_s > max_q))) max_d = rdata_s;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    busy    = 1'b1;
    done    = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    step_wr = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (sw_start) begin
          err_d   = 1'b0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (cfg_bad) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StRdReq;
        end
      end
      StRdReq: begin
        rd_req = 1'b1;
        if (rd_gnt) state_d = StRdWait;
      end
      StRdWait: begin
        if (rd_rvalid) state_d = win_last ? StWrReq : StRdReq;
      end
      StWrReq: begin
        wr_req = 1'b1;
        if (wr_gnt) begin
          step_wr = 1'b1;
          state_d = out_last ? StDone : StRdReq;
        end
      end
      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign err     = err_q;
  assign rd_addr = rd_req ? gen_rd_addr : '0;
  assign wr_addr = wr_req ? gen_wr_addr : '0;
  assign wr_data = wr_req ? result : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      err_q     <= 1'b0;
      max_q     <= '0;
      rd_base_q <= '0;
      wr_base_q <= '0;
      m_q       <= '0;
      n_q       <= '0;
      pm_q      <= '0;
      pn_q      <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      max_q   <= max_d;
      if (cfg_load) begin
        rd_base_q <= sw_rd_addr;
        wr_base_q <= sw_wr_addr;
        m_q       <= sw_m;
        n_q       <= sw_n;
        pm_q      <= sw_pm;
        pn_q      <= sw_pn;
      end
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Directed bench for pool_engine with a negedge memory model (stalls, read latency, monitors).
module tb_pool_engine;

  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 8;
  localparam int unsigned DIMW = 8;
  localparam int unsigned WW   = 3;

  logic          clk, rst_n, sw_start, sw_mode;
  logic [AW-1:0] sw_rd_addr, sw_wr_addr;
  logic [DIMW-1:0] sw_m, sw_n;
  logic [WW-1:0] sw_pm, sw_pn;
  logic          busy, done, err, rd_req, rd_gnt, rd_rvalid, wr_req, wr_gnt;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_rdata, wr_data;

  pool_engine #(
    .ADDR_WIDTH(AW),
    .DATA_W    (DW),
    .DIM_W     (DIMW),
    .MAX_WIN   (4),
    .WIN_W     (WW),
    .ACC_W     (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_start  (sw_start),
    .sw_rd_addr(sw_rd_addr),
    .sw_wr_addr(sw_wr_addr),
    .sw_m      (sw_m),
    .sw_n      (sw_n),
    .sw_pm     (sw_pm),
    .sw_pn     (sw_pn),
    .sw_mode   (sw_mode),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_rvalid (rd_rvalid),
    .rd_rdata  (rd_rdata),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory model state (written only by the negedge process unless noted).
  logic [DW-1:0] mem [0:4095];
  logic [AW-1:0] wlog_addr [0:255];
  logic [DW-1:0] wlog_data [0:255];
  logic          rd_pend, rd_wait_prev, wr_wait_prev;
  logic [AW-1:0] g_addr, rd_prev_addr, wr_prev_addr, addr_diff;
  logic [DW-1:0] rd_pdata, wr_prev_data;
  int            rd_lat, rd_stall, wr_stall, off;
  int            wr_cnt = 0, rd_cnt = 0, done_cnt = 0, rq_cyc = 0;
  int            rd_viol = 0, wr_viol = 0, two_out = 0, left_viol = 0;
  // Controlled by the stimulus process.
  logic          rand_mode, gnt_block;
  logic [AW-1:0] mon_rb;
  int            mon_n, mon_lr, mon_lc;

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_gnt       = 1'b0;
      wr_gnt       = 1'b0;
      rd_rvalid    = 1'b0;
      rd_pend      = 1'b0;
      rd_wait_prev = 1'b0;
      wr_wait_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (rd_req) rq_cyc++;
      rd_rvalid = 1'b0;
      if (rd_pend) begin
        rd_lat--;
        if (rd_lat == 0) begin
          rd_rvalid = 1'b1;
          rd_rdata  = rd_pdata;
          rd_pend   = 1'b0;
        end
      end
      if (rd_gnt) begin
        rd_gnt   = 1'b0;
        rd_pdata = mem[g_addr];
        rd_lat   = rand_mode ? int'($urandom_range(1, 8)) - 1 : 0;
        if (rd_lat == 0) begin
          rd_rvalid = 1'b1;
          rd_rdata  = rd_pdata;
        end else begin
          rd_pend = 1'b1;
        end
      end
      if (rd_wait_prev && (!rd_req || rd_addr != rd_prev_addr)) rd_viol++;
      if (rd_req && rd_pend) two_out++;
      if (rd_req) begin
        if (!rd_wait_prev) rd_stall = rand_mode ? int'($urandom_range(0, 5)) : 0;
        if (rd_stall == 0 && !gnt_block) begin
          rd_gnt       = 1'b1;
          g_addr       = rd_addr;
          rd_wait_prev = 1'b0;
          rd_cnt++;
          addr_diff = rd_addr - mon_rb;
          off       = int'(addr_diff);
          if (mon_n != 0 && ((off / mon_n) >= mon_lr || (off % mon_n) >= mon_lc)) left_viol++;
        end else begin
          if (rd_stall != 0) rd_stall--;
          rd_wait_prev = 1'b1;
          rd_prev_addr = rd_addr;
        end
      end else begin
        rd_wait_prev = 1'b0;
      end

      if (wr_wait_prev && (!wr_req || wr_addr != wr_prev_addr || wr_data != wr_prev_data))
        wr_viol++;
      wr_gnt = 1'b0;
      if (wr_req) begin
        if (!wr_wait_prev) wr_stall = rand_mode ? int'($urandom_range(0, 5)) : 0;
        if (wr_stall == 0 && !gnt_block) begin
          wr_gnt                 = 1'b1;
          wlog_addr[wr_cnt % 256] = wr_addr;
          wlog_data[wr_cnt % 256] = wr_data;
          wr_cnt++;
          wr_wait_prev = 1'b0;
        end else begin
          if (wr_stall != 0) wr_stall--;
          wr_wait_prev = 1'b1;
          wr_prev_addr = wr_addr;
          wr_prev_data = wr_data;
        end
      end else begin
        wr_wait_prev = 1'b0;
      end
    end
  end

  task automatic drive_start(input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                             input int m, input int n, input int pm, input int pn,
                             input logic mode);
    mon_rb     = rb;
    mon_n      = n;
    mon_lr     = (pm != 0) ? (m / pm) * pm : 0;
    mon_lc     = (pn != 0) ? (n / pn) * pn : 0;
    sw_rd_addr = rb;
    sw_wr_addr = wb;
    sw_m       = DIMW'(m);
    sw_n       = DIMW'(n);
    sw_pm      = WW'(pm);
    sw_pn      = WW'(pn);
    sw_mode    = mode;
    sw_start   = 1'b1;
    @(posedge clk);
    #2;
    sw_start   = 1'b0;
  endtask

  task automatic run_pool(input string tag, input logic [AW-1:0] rb, input logic [AW-1:0] wb,
                          input int m, input int n, input int pm, input int pn,
                          input logic mode, output int wbase, output int nrd,
                          output int ndone, output int nrq);
    int  b_rd = rd_cnt;
    int  b_dn = done_cnt;
    int  b_rq = rq_cyc;
    int  b_lo = left_viol;
    bit  seen = 1'b0;
    wbase = wr_cnt;
    drive_start(rb, wb, m, n, pm, pn, mode);
    check_eq({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check_eq({tag, "_err_clear_on_start"}, 32'(err), 32'd0);
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(posedge clk);
      #2;
      if (done) begin
        seen = 1'b1;
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      end
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_leftover_reads"}, 32'(left_viol - b_lo), 32'd0);
    nrd   = rd_cnt - b_rd;
    ndone = done_cnt - b_dn;
    nrq   = rq_cyc - b_rq;
  endtask

  task automatic check_writes(input string tag, input int wbase, input int cnt,
                              input logic [AW-1:0] wb, input logic [DW-1:0] d0,
                              input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                              input logic [DW-1:0] d3);
    logic [DW-1:0] exp_d [4];
    exp_d = '{d0, d1, d2, d3};
    check_eq({tag, "_wr_count"}, 32'(wr_cnt - wbase), 32'(cnt));
    for (int i = 0; i < cnt; i++) begin
      check_eq({tag, "_wr_addr"}, 32'(wlog_addr[(wbase + i) % 256]), 32'(wb + AW'(i)));
      check_eq({tag, "_wr_data"}, 32'(wlog_data[(wbase + i) % 256]), 32'(exp_d[i]));
    end
  endtask

  task automatic run_err(input string tag, input int m, input int n, input int pm,
                         input int pn, input logic mode);
    int wb0, nrd, ndn, nrq;
    run_pool(tag, 12'h500, 12'h580, m, n, pm, pn, mode, wb0, nrd, ndn, nrq);
    check_eq({tag, "_err"}, 32'(err), 32'd1);
    check_eq({tag, "_done_once"}, 32'(ndn), 32'd1);
    check_eq({tag, "_no_rd_req"}, 32'(nrq), 32'd0);
    check_eq({tag, "_no_writes"}, 32'(wr_cnt - wb0), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int  wb0, nrd, ndn, nrq, b_dn;
    bit  seen;
    rst_n      = 1'b0;
    sw_start   = 1'b0;
    sw_mode    = 1'b0;
    sw_rd_addr = '0;
    sw_wr_addr = '0;
    sw_m       = '0;
    sw_n       = '0;
    sw_pm      = '0;
    sw_pn      = '0;
    rd_rdata   = '0;
    rand_mode  = 1'b0;
    gnt_block  = 1'b0;
    mon_rb     = '0;
    mon_n      = 0;
    mon_lr     = 0;
    mon_lc     = 0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) mem[12'h100 + i] = 8'(i);
    for (int i = 0; i < 35; i++) mem[12'h300 + i] = 8'h80;
    mem[12'h300 + 1 * 7 + 2] = 8'h7f;
    mem[12'h300 + 0 * 7 + 3] = 8'h7f;
    mem[12'h300 + 3 * 7 + 1] = 8'h7f;
    mem[12'h300 + 2 * 7 + 5] = 8'h7f;
    mem[12'h300 + 4 * 7 + 0] = 8'h7f;
    mem[12'h300 + 0 * 7 + 6] = 8'h7f;
    mem[12'h400] = 8'hff; mem[12'h401] = 8'hfe; mem[12'h402] = 8'hfd; mem[12'h403] = 8'hfc;
    mem[12'h410] = 8'h01; mem[12'h411] = 8'h01; mem[12'h412] = 8'h01; mem[12'h413] = 8'h02;

    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rd_req", 32'(rd_req), 32'd0);
    check_eq("rst_wr_req", 32'(wr_req), 32'd0);
    check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // 4x4 ramp, 2x2 max, zero-wait memory.
    run_pool("max4x4", 12'h100, 12'h200, 4, 4, 2, 2, 1'b0, wb0, nrd, ndn, nrq);
    check_writes("max4x4", wb0, 4, 12'h200, 8'd5, 8'd7, 8'd13, 8'd15);
    check_eq("max4x4_done_once", 32'(ndn), 32'd1);
    check_eq("max4x4_reads", 32'(nrd), 32'd16);

    // 5x7 signed, 2x3 windows; last row and column are leftovers.
    run_pool("max5x7", 12'h300, 12'h380, 5, 7, 2, 3, 1'b0, wb0, nrd, ndn, nrq);
    check_writes("max5x7", wb0, 4, 12'h380, 8'h7f, 8'h7f, 8'h7f, 8'h7f);
    check_eq("max5x7_reads", 32'(nrd), 32'd24);

    // Random grant stalls and read latency.
    rand_mode = 1'b1;
    run_pool("rand4x4", 12'h100, 12'h210, 4, 4, 2, 2, 1'b0, wb0, nrd, ndn, nrq);
    check_writes("rand4x4", wb0, 4, 12'h210, 8'd5, 8'd7, 8'd13, 8'd15);
    check_eq("rand4x4_reads", 32'(nrd), 32'd16);
    rand_mode = 1'b0;

    // Configuration errors.
    run_err("err_pm0", 4, 4, 0, 2, 1'b0);
    run_err("err_m_lt_pm", 3, 4, 4, 1, 1'b0);
    run_err("err_pn5", 8, 8, 2, 5, 1'b0);

    // err clears on the next valid start.
    run_pool("after_err", 12'h100, 12'h220, 4, 4, 2, 2, 1'b0, wb0, nrd, ndn, nrq);
    check_eq("after_err_err", 32'(err), 32'd0);
    check_writes("after_err", wb0, 4, 12'h220, 8'd5, 8'd7, 8'd13, 8'd15);

`ifdef AVG_POOL_EN
    run_pool("avg_neg", 12'h400, 12'h480, 2, 2, 2, 2, 1'b1, wb0, nrd, ndn, nrq);
    check_writes("avg_neg", wb0, 1, 12'h480, 8'hfd, 8'h00, 8'h00, 8'h00);
    run_pool("avg_pos", 12'h410, 12'h490, 2, 2, 2, 2, 1'b1, wb0, nrd, ndn, nrq);
    check_writes("avg_pos", wb0, 1, 12'h490, 8'h01, 8'h00, 8'h00, 8'h00);
    run_err("avg_pm3", 3, 3, 3, 1, 1'b1);
`else
    // Without averaging, sw_mode has no effect.
    run_pool("mode_ignored", 12'h100, 12'h230, 4, 4, 2, 2, 1'b1, wb0, nrd, ndn, nrq);
    check_writes("mode_ignored", wb0, 4, 12'h230, 8'd5, 8'd7, 8'd13, 8'd15);
`endif

    // Reset while a read request is pending.
    gnt_block = 1'b1;
    drive_start(12'h100, 12'h240, 4, 4, 2, 2, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (rd_req) seen = 1'b1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    check_eq("rst_mid_rd_req_seen", 32'(rd_req), 32'd1);
    b_dn  = done_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    check_eq("rst_mid_rd_req", 32'(rd_req), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_done", 32'(done), 32'd0);
    rst_n     = 1'b1;
    gnt_block = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check_eq("rst_mid_no_done", 32'(done_cnt - b_dn), 32'd0);
    run_pool("post_rst", 12'h100, 12'h250, 4, 4, 2, 2, 1'b0, wb0, nrd, ndn, nrq);
    check_writes("post_rst", wb0, 4, 12'h250, 8'd5, 8'd7, 8'd13, 8'd15);
    check_eq("post_rst_done_once", 32'(ndn), 32'd1);

    check_eq("rd_req_stable", 32'(rd_viol), 32'd0);
    check_eq("wr_req_stable", 32'(wr_viol), 32'd0);
    check_eq("single_outstanding", 32'(two_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
